// File: rtl/tilexy_mort_rcv_pkg.sv
// Shared types for the tile XY write-request receiver.
// Queue entry layout, ack packet format and FSM states.
package tilexy_mort_rcv_pkg;

  localparam int DATA_W = 528;
  localparam int ADDR_W = 37;
  localparam int SIZE_W = 12;
  localparam int MASK_W = 10;
  localparam int BEAT_W = 264;

  typedef struct packed {
    logic              expun;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mort_entry_t;

  typedef struct packed {
    logic [4:0]        ty;
    logic [4:0]        tx;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        status;
  } ack_pkt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_INV,
    S_ACK
  } rcv_state_t;

  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_EXPUN = 2'b10;
  localparam logic [1:0] ST_FLUSH = 2'b11;

  function automatic ack_pkt_t mk_ack(
    input logic [4:0]        ty,
    input logic [4:0]        tx,
    input logic [ADDR_W-1:0] addr,
    input logic [1:0]        st
  );
    mk_ack.ty     = ty;
    mk_ack.tx     = tx;
    mk_ack.addr   = addr;
    mk_ack.status = st;
  endfunction

endpackage

// File: rtl/tilexy_mort_rcv_q.sv
// Receive queue: circular buffer with occupancy count.
// Head entry is read straight from the storage array.
module tilexy_mort_rcv_q
  import tilexy_mort_rcv_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  mort_entry_t wdata_i,
  output mort_entry_t rdata_o,
  output logic [CW-1:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  mort_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/tilexy_mort_rcv.sv
// Tile XY write-request receiver: queues delivered requests,
// drains them to the L2 bank as beats or invalidates, then acks.
module tilexy_mort_rcv
  import tilexy_mort_rcv_pkg::*;
#(
  parameter int TILE_X     = 0,
  parameter int TILE_Y     = 0,
  parameter int DEPTH      = 8,
  parameter int HOLD_SLACK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic [527:0] in_data,
  input  logic [36:0]  in_addr,
  input  logic [11:0]  in_size,
  input  logic         in_expun,
  output logic         hold,
  output logic         bk_valid,
  input  logic         bk_ready,
  output logic [37:0]  bk_addr,
  output logic [263:0] bk_data,
  output logic [9:0]   bk_mask,
  output logic         bk_inv,
  output logic         ack_en,
  input  logic         ack_ready,
  output logic [48:0]  ack_pkt,
  output logic         overflow,
  output logic         busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] HOLD_TH = CW'(DEPTH - HOLD_SLACK);
  localparam logic [4:0] TY = 5'(TILE_Y);
  localparam logic [4:0] TX = 5'(TILE_X);

  rcv_state_t    state_q;
  mort_entry_t   went, hd;
  logic [CW-1:0] count;
  logic          push, pop, full, empty;
  logic          hold_q, ovf_q;
  logic          bk_valid_q, bk_inv_q, ack_en_q;
  logic [37:0]   bk_addr_q;
  logic [263:0]  bk_data_q;
  logic [9:0]    bk_mask_q;
  ack_pkt_t      ack_q;
  logic          unused_sz;

  assign went = '{expun: in_expun, size: in_size,
                  addr: in_addr, data: in_data};
  assign pop  = (state_q == S_ACK) && ack_ready;
  // A full queue still takes a push when the head leaves this cycle.
  assign push = in_en && (!full || pop);
  assign unused_sz = ^hd.size[11:10];

  tilexy_mort_rcv_q #(.DEPTH(DEPTH)) u_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (went),
    .rdata_o (hd),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      hold_q <= (count >= HOLD_TH);
      if (in_en && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bk_valid_q <= 1'b0;
      bk_inv_q   <= 1'b0;
      bk_addr_q  <= '0;
      bk_data_q  <= '0;
      bk_mask_q  <= '0;
      ack_en_q   <= 1'b0;
      ack_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (!empty) begin
          bk_addr_q <= {hd.addr, 1'b0};
          bk_mask_q <= hd.size[9:0];
          if (hd.expun) begin
            state_q    <= S_INV;
            bk_valid_q <= 1'b1;
            bk_inv_q   <= 1'b1;
            bk_data_q  <= '0;
          end else if (hd.size[9:0] == '0) begin
            state_q  <= S_ACK;
            ack_en_q <= 1'b1;
            ack_q    <= mk_ack(TY, TX, hd.addr, ST_FLUSH);
          end else begin
            state_q    <= S_BEAT0;
            bk_valid_q <= 1'b1;
            bk_inv_q   <= 1'b0;
            bk_data_q  <= hd.data[263:0];
          end
        end
        S_BEAT0: if (bk_ready) begin
          state_q   <= S_BEAT1;
          bk_addr_q <= {hd.addr, 1'b1};
          bk_data_q <= hd.data[527:264];
        end
        S_BEAT1: if (bk_ready) begin
          state_q    <= S_ACK;
          bk_valid_q <= 1'b0;
          ack_en_q   <= 1'b1;
          ack_q      <= mk_ack(TY, TX, hd.addr, ST_WRITE);
        end
        S_INV: if (bk_ready) begin
          state_q    <= S_ACK;
          bk_valid_q <= 1'b0;
          bk_inv_q   <= 1'b0;
          ack_en_q   <= 1'b1;
          ack_q      <= mk_ack(TY, TX, hd.addr, ST_EXPUN);
        end
        S_ACK: if (ack_ready) begin
          state_q  <= S_IDLE;
          ack_en_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hold     = hold_q;
  assign overflow = ovf_q;
  assign bk_valid = bk_valid_q;
  assign bk_inv   = bk_inv_q;
  assign bk_addr  = bk_addr_q;
  assign bk_data  = bk_data_q;
  assign bk_mask  = bk_mask_q;
  assign ack_en   = ack_en_q;
  assign ack_pkt  = ack_q;
  assign busy     = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_tilexy_mort_rcv.sv
// Directed bench for tilexy_mort_rcv: vector table plus
// back-pressure, overflow, ack stall and mid-beat reset sequences.
module tb_tilexy_mort_rcv;

  logic         clk, rst;
  logic         in_en, in_expun;
  logic [527:0] in_data;
  logic [36:0]  in_addr;
  logic [11:0]  in_size;
  logic         hold, bk_valid, bk_ready, bk_inv;
  logic [37:0]  bk_addr;
  logic [263:0] bk_data;
  logic [9:0]   bk_mask;
  logic         ack_en, ack_ready, overflow, busy;
  logic [48:0]  ack_pkt;

  tilexy_mort_rcv #(
    .TILE_X(3), .TILE_Y(5), .DEPTH(8), .HOLD_SLACK(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_en(in_en), .in_data(in_data), .in_addr(in_addr),
    .in_size(in_size), .in_expun(in_expun),
    .hold(hold),
    .bk_valid(bk_valid), .bk_ready(bk_ready),
    .bk_addr(bk_addr), .bk_data(bk_data),
    .bk_mask(bk_mask), .bk_inv(bk_inv),
    .ack_en(ack_en), .ack_ready(ack_ready), .ack_pkt(ack_pkt),
    .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         expun;
    logic [11:0]  size;
    logic [36:0]  addr;
    logic [263:0] lo;
    logic [263:0] hi;
    logic [1:0]   st;
  } vec_t;

  typedef struct packed {
    logic         inv;
    logic [9:0]   mask;
    logic [37:0]  addr;
    logic [263:0] data;
  } beat_t;

  int    passes = 0;
  int    total  = 0;
  vec_t  vecs [6];
  beat_t bq [$];
  logic [48:0] aq [$];

  task automatic chk(input string nm, input logic [527:0] act,
                     input logic [527:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    else
      passes++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_v(input vec_t v);
    in_en    = 1'b1;
    in_expun = v.expun;
    in_size  = v.size;
    in_addr  = v.addr;
    in_data  = {v.hi, v.lo};
    step();
  endtask

  function automatic vec_t mkv(input int i);
    logic [7:0] b;
    b = 8'(i + 16);
    mkv.expun = 1'b0;
    mkv.size  = 12'h3FF;
    mkv.addr  = 37'h100 + 37'(i * 64);
    mkv.lo    = {33{b}};
    mkv.hi    = ~{33{b}};
    mkv.st    = 2'b01;
  endfunction

  function automatic logic [48:0] exp_ack(input vec_t v);
    return {5'd5, 5'd3, v.addr, v.st};
  endfunction

  task automatic add_exp(input vec_t v);
    if (v.st == 2'b01) begin
      bq.push_back({1'b0, v.size[9:0], v.addr, 1'b0, v.lo});
      bq.push_back({1'b0, v.size[9:0], v.addr, 1'b1, v.hi});
    end else if (v.st == 2'b10) begin
      bq.push_back({1'b1, v.size[9:0], v.addr, 1'b0, 264'b0});
    end
    aq.push_back(exp_ack(v));
  endtask

  // bk_ready/ack_ready are held high, so each visible valid is one transfer.
  task automatic drain(input int cycles, input int exp_acks);
    int    acks;
    beat_t b;
    acks = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bk_valid) begin
        if (bq.size() == 0) begin
          total++;
          $display("FAIL extra_beat got=%0h want=none", bk_addr);
        end else begin
          b = bq.pop_front();
          chk("drain_beat", {bk_inv, bk_mask, bk_addr, bk_data}, b);
        end
      end
      if (ack_en) begin
        acks++;
        if (aq.size() == 0) begin
          total++;
          $display("FAIL extra_ack got=%0h want=none", ack_pkt);
        end else begin
          chk("drain_ack", ack_pkt, aq.pop_front());
        end
      end
      step();
    end
    chk("ack_count", 528'(acks), 528'(exp_acks));
  endtask

  vec_t v, e0;

  initial begin
    vecs[0] = '{1'b0, 12'h3FF, 37'h10000_0040,
                {33{8'hAA}}, {33{8'hBB}}, 2'b01};
    vecs[1] = '{1'b0, 12'h001, 37'h0_1234_5678,
                {33{8'h5A}}, {33{8'hC3}}, 2'b01};
    vecs[2] = '{1'b1, 12'h3FF, 37'h55,
                {33{8'h11}}, {33{8'h22}}, 2'b10};
    vecs[3] = '{1'b0, 12'h000, 37'h1F_FFFF_FFC0,
                {33{8'h33}}, {33{8'h44}}, 2'b11};
    vecs[4] = '{1'b0, 12'hA00, 37'h0_0BAD_F00D,
                {33{8'h01}}, {33{8'hFE}}, 2'b01};
    vecs[5] = '{1'b1, 12'h000, 37'h1_ABCD_EF00,
                {33{8'h77}}, {33{8'h88}}, 2'b10};

    rst = 1'b1; in_en = 1'b0; in_expun = 1'b0;
    in_data = '0; in_addr = '0; in_size = '0;
    bk_ready = 1'b1; ack_ready = 1'b1;
    step(); step(); step();
    chk("reset_outs", {bk_valid, bk_inv, bk_addr, bk_data, bk_mask,
        ack_en, ack_pkt, hold, overflow, busy}, '0);
    rst = 1'b0;
    step();
    chk("idle_outs", {bk_valid, ack_en, hold, overflow, busy}, '0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      push_v(v);
      in_en = 1'b0;
      chk("push_idle", {busy, bk_valid, ack_en}, 3'b100);
      step();
      if (v.st == 2'b01) begin
        chk("beat0", {bk_valid, bk_inv, bk_mask, bk_addr, bk_data},
            {1'b1, 1'b0, v.size[9:0], v.addr, 1'b0, v.lo});
        step();
        chk("beat1", {bk_valid, bk_inv, bk_mask, bk_addr, bk_data},
            {1'b1, 1'b0, v.size[9:0], v.addr, 1'b1, v.hi});
        step();
      end else if (v.st == 2'b10) begin
        chk("inv_cmd", {bk_valid, bk_inv, bk_addr, bk_data},
            {1'b1, 1'b1, v.addr, 1'b0, 264'b0});
        step();
      end
      chk("ack", {bk_valid, ack_en, ack_pkt},
          {1'b0, 1'b1, exp_ack(v)});
      step();
      chk("post_ack", {busy, bk_valid, ack_en}, 3'b000);
    end

    // ack held while ack_ready is low
    v = mkv(50); v.size = 12'h000; v.st = 2'b11;
    ack_ready = 1'b0;
    push_v(v);
    in_en = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("ack_stall", {ack_en, ack_pkt}, {1'b1, exp_ack(v)});
      step();
    end
    ack_ready = 1'b1;
    step();
    chk("ack_release", {ack_en, busy}, 2'b00);

    // back-pressure: six entries pile up behind a stalled bank
    bk_ready = 1'b0;
    e0 = mkv(0);
    for (int i = 0; i < 6; i++) begin
      v = mkv(i);
      add_exp(v);
      push_v(v);
      if (i >= 1)
        chk("bp_stable", {bk_valid, bk_addr, bk_data},
            {1'b1, e0.addr, 1'b0, e0.lo});
      if (i == 4) chk("hold_low", 528'(hold), 528'(0));
    end
    in_en = 1'b0;
    step();
    chk("hold_high", 528'(hold), 528'(1));
    chk("bp_stable_end", {bk_valid, bk_addr, bk_data},
        {1'b1, e0.addr, 1'b0, e0.lo});
    bk_ready = 1'b1;
    drain(40, 6);
    chk("bp_done", {hold, busy, overflow}, 3'b000);

    // overflow: ninth push into a full, stalled queue is dropped
    bk_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      v = mkv(20 + i);
      if (i < 8) add_exp(v);
      push_v(v);
      if (i == 7) chk("ovf_low", 528'(overflow), 528'(0));
    end
    in_en = 1'b0;
    chk("ovf_set", 528'(overflow), 528'(1));
    step();
    chk("ovf_hold", 528'(hold), 528'(1));
    bk_ready = 1'b1;
    drain(60, 8);
    chk("ovf_sticky", {overflow, busy}, 2'b10);

    // reset during the second beat
    v = mkv(40);
    push_v(v);
    in_en = 1'b0;
    step();
    step();
    chk("pre_rst_beat1", {bk_valid, bk_addr}, {1'b1, v.addr, 1'b1});
    rst = 1'b1;
    #1;
    chk("rst_async", {bk_valid, bk_inv, bk_addr, bk_data, bk_mask,
        ack_en, ack_pkt, hold, overflow, busy}, '0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_busy", 528'(busy), 528'(0));
    drain(10, 0);
    v = mkv(41); v.size = 12'h000; v.st = 2'b11;
    push_v(v);
    in_en = 1'b0;
    step();
    chk("rst_next_ack", {bk_valid, ack_en, ack_pkt},
        {1'b0, 1'b1, exp_ack(v)});
    step();
    chk("rst_final", {busy, ack_en, overflow}, 3'b000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/tilexy_mort_rcv.md
Name: tileXY_mort_rcv

Overview:
Destination-side receiver for the tile XY write-request network. It consumes the per-tile delivered-request stream (outen / reqmort_* bundle) and buffers each entry in a small queue. It then drains each entry into the local L2 bank as two 264-bit beats, or as a single invalidate command for expunges. After each completed entry it emits an ack packet toward the ring injector.

Parameters:
TILE_X, 0, this tile's X coordinate (5 bits used)
TILE_Y, 0, this tile's Y coordinate (5 bits used)
DEPTH, 8, receive queue entries (power of 2, >=4)
HOLD_SLACK, 2, free entries kept in reserve before asserting hold

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_en  in  1  delivered request valid (driven by the sender's outen); no ready path
in_data  in  528  line data, 66 bytes
in_addr  in  37  line address
in_size  in  12  {shared, exclusive, phymsk[9:0]}
in_expun  in  1  expunge request
hold  out  1  back-pressure to the sender
bk_valid  out  1  bank command valid
bk_ready  in  1  bank accepts the command
bk_addr  out  38  {line addr, beat}
bk_data  out  264  beat data
bk_mask  out  10  phymsk
bk_inv  out  1  invalidate command
ack_en  out  1  ack valid
ack_ready  in  1  ack accepted
ack_pkt  out  49  {TILE_Y[4:0], TILE_X[4:0], addr[36:0], status[1:0]}
overflow  out  1  sticky: an entry was dropped
busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst=1) values: queue empty, count=0, FSM=IDLE, overflow=0. All outputs are 0.
- Push:
  - in_en=1 writes {expun, size, addr, data} at wptr when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set; overflow clears only on rst.
  - wptr and rptr wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits wide.
- hold: registered, equal to (count >= DEPTH-HOLD_SLACK). The sender sees it one cycle late, which is why the slack exists.
- FSM states: IDLE, BEAT0, BEAT1, INV, ACK.
- IDLE, when the queue is non-empty, inspects the head entry:
  - expun=1 -> INV.
  - expun=0 and phymsk==0 (flush-only) -> ACK.
  - otherwise -> BEAT0.
  - Head decode happens in the cycle after the push at the earliest, so queue-to-bank latency is 1 cycle.
- BEAT0: bk_valid=1, bk_addr={addr,0}, bk_data=data[263:0], bk_mask=phymsk, bk_inv=0. Moves to BEAT1 on bk_ready.
- BEAT1: same, with bk_addr={addr,1} and bk_data=data[527:264]. Moves to ACK on bk_ready.
- INV: bk_valid=1, bk_inv=1, bk_addr={addr,0}, bk_data=0. Moves to ACK on bk_ready.
- ACK: ack_en=1 with status:
  - 2'b01 write
  - 2'b10 expunge
  - 2'b11 flush-only
  - 2'b00 reserved
  - On ack_ready: pop the head and return to IDLE. A non-empty queue is re-inspected in the next cycle, so there is one IDLE bubble per entry.
- Command stability: bk_* and ack_* are driven from registered head fields. They must stay stable while valid is high and ready is low.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Empty queue in IDLE: nothing is issued and busy=0.
- Reset mid-operation: any in-flight beat is abandoned with no ack; the bank sees bk_valid drop asynchronously.

Decomposition:
- Package tileXY_pkg:
  - wrreq/wrAreq field offset constants
  - mort_entry_t {expun, size, addr, data}
  - ack_pkt_t
  - rcv_state_t enum
  - ack status constants
- Sub-module tileXY_mort_q: parameterised DEPTH queue with count, full, empty and async reset. The top level holds only the FSM, hold/overflow logic and output muxing.

Test Plan:
- Single write: addr=0x1_0000_0040, phymsk=0x3FF, data lower half=A, upper half=B, bk_ready=1, ack_ready=1 -> BEAT0 {addr,0}/A, then BEAT1 {addr,1}/B on consecutive cycles, then ack status 01, ack_pkt[48:39]={TILE_Y,TILE_X}.
- Expunge: in_expun=1, addr=0x55 -> one bk_inv=1 command, then ack status 10; no data beats.
- Flush-only: phymsk=0 -> no bk_valid; ack status 11 one cycle after the push.
- Back-pressure: bk_ready=0 for 5 cycles while 6 entries are pushed (DEPTH=8) -> hold=1 once count reaches 6; bk_addr/bk_data stay stable throughout; all 6 drain in order once bk_ready=1.
- Overflow: 9 back-to-back pushes with bk_ready=0 -> 9th dropped, overflow=1, count=8. Exactly 8 acks follow in FIFO order.
- Mid-beat reset: assert rst during BEAT1 -> all outputs 0 immediately; after release, busy=0, queue empty, no ack for the aborted entry.
